vram_arbiter: RTL and testbench

Shares the single-port video RAM between the CPU bus and the CRT character fetcher. Both requesters use a req/complete handshake. The video fetch gets fixed priority, with a bounded-starvation guard so the CPU always makes progress. The block sits between the CPU-side VRAM window decode, the CRT controller's VAD/vram_cs/VDI/vram_complete port, and the external SRAM pins.

---
 rtl/vram_arbiter_pkg.sv | 20 ++
 rtl/vram_arbiter_if.sv | 50 +++++
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared video-subsystem definitions for the VRAM arbiter: the arbiter FSM
// state encoding and the encoding of which requester owns the memory.
// No ports (package).
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the three sides of the VRAM arbiter: the CPU req/complete port, the
// CRT fetch port (vram_cs/VAD/VDI/vram_complete) and the external SRAM pins.
// Modports:
//   slave  - the arbiter: takes requests and mem_din, drives data/complete/SRAM
//   master - the environment: CPU, CRT controller and SRAM
// -----------------------------------------------------------------------------
interface vram_arbiter_if;

    // CPU side
    logic        cpu_req;
    logic        cpu_rw;        // 1 = read, 0 = write
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_complete;

    // CRT character fetch side
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_complete;

    // External SRAM pins
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ce;
    logic        mem_we;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_di,
        output cpu_do, cpu_complete,
        input  vid_req, vid_addr,
        output vid_data, vid_complete,
        output mem_addr, mem_dout, mem_ce, mem_we,
        input  mem_din
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_di,
        input  cpu_do, cpu_complete,
        output vid_req, vid_addr,
        input  vid_data, vid_complete,
        input  mem_addr, mem_dout, mem_ce, mem_we,
        output mem_din
    );

endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port video SRAM between the CPU and the CRT character
// fetcher. Video has fixed priority; after STARVE_LIMIT consecutive video
// grants made while the CPU was waiting, the CPU wins the next arbitration.
// Each access holds the SRAM for WAIT_STATES+1 cycles, followed by a one-cycle
// completion pulse to the owner.
// Ports:
//   clk - system clock
//   rst - asynchronous, active-high reset
//   bus - vram_arbiter_if.slave: CPU port, video port and SRAM pins
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int WAIT_STATES  = 1,   // 0..7
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);

    localparam logic [2:0] WAIT_LAST  = 3'(WAIT_STATES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_e  state_q,    state_d;
    arb_owner_e  owner_q,    owner_d;
    logic [15:0] addr_q,     addr_d;
    logic [7:0]  wdata_q,    wdata_d;
    logic        write_q,    write_d;
    logic [2:0]  wait_q,     wait_d;
    logic [3:0]  starve_q,   starve_d;
    logic [7:0]  cpu_do_q,   cpu_do_d;
    logic [7:0]  vid_data_q, vid_data_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_VID;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            wait_q     <= '0;
            starve_q   <= '0;
            cpu_do_q   <= '0;
            vid_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            cpu_do_q   <= cpu_do_d;
            vid_data_q <= vid_data_d;
        end
    end

    // NOTE: every next-state signal defaults to its current value before the
    // case statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        cpu_do_d   = cpu_do_q;
        vid_data_d = vid_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.vid_req) begin
                    state_d = ACCESS;
                    wait_d  = '0;
                    // CPU only beats a pending video fetch once it has been
                    // passed over STARVE_LIMIT times in a row.
                    if (bus.cpu_req && (!bus.vid_req || starve_q == STARVE_MAX)) begin
                        owner_d  = OWN_CPU;
                        addr_d   = bus.cpu_addr;
                        write_d  = !bus.cpu_rw;
                        wdata_d  = bus.cpu_di;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_VID;
                        addr_d  = bus.vid_addr;
                        write_d = 1'b0;
                        wdata_d = '0;
                        if (bus.cpu_req && starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end

            ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = DONE;
                    // Read data is captured on the last memory cycle so it is
                    // already on the owner's data port during the DONE pulse.
                    if (!write_q) begin
                        if (owner_q == OWN_CPU) cpu_do_d   = bus.mem_din;
                        else                    vid_data_d = bus.mem_din;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // Memory pins decode straight from registered state, so an asynchronous
    // reset drops mem_ce/mem_we immediately.
    assign bus.mem_ce       = (state_q == ACCESS);
    assign bus.mem_we       = bus.mem_ce && write_q;
    assign bus.mem_addr     = bus.mem_ce ? addr_q  : '0;
    assign bus.mem_dout     = bus.mem_we ? wdata_q : '0;

    assign bus.cpu_complete = (state_q == DONE) && (owner_q == OWN_CPU);
    assign bus.vid_complete = (state_q == DONE) && (owner_q == OWN_VID);
    assign bus.cpu_do       = cpu_do_q;
    assign bus.vid_data     = vid_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Self-checking bench for vram_arbiter (WAIT_STATES=1, STARVE_LIMIT=4).
// A transaction-timeline model predicts, from each grant cycle, which cycles
// the SRAM is busy, when the completion pulse lands and what read data must
// appear; a negedge compare process checks every cycle against it. Directed
// scenarios add hand-computed literal expectations, then a random phase
// drives both requesters with $urandom.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int WS    = 1;
    localparam int LIMIT = 4;
    localparam int BOUND = (LIMIT + 2) * (WS + 3);

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_arbiter_if bus ();

    vram_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model (environment) ----------------
    bit [7:0]    sram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_a  = '0;
    logic [7:0]  pre_d  = '0;

    assign bus.mem_din = sram[bus.mem_addr];

    always @(posedge clk) begin
        if (pre_we)     sram[pre_a]        <= pre_d;
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_dout;
    end

    // ---------------- Reference model ----------------
    // Accesses are serialised, so one grant record describes everything:
    // grant in idle cycle g -> SRAM busy g+1..g+1+WS, complete at g+2+WS,
    // next arbitration possible in cycle g+3+WS.
    int          cyc      = 0;
    int          free_at  = 0;
    bit          g_valid  = 1'b0;
    int          g_cyc    = 0;
    bit          g_cpu    = 1'b0;
    bit          g_write  = 1'b0;
    logic [15:0] g_addr   = '0;
    logic [7:0]  g_data   = '0;
    logic [7:0]  g_rdata  = '0;
    int          starve   = 0;
    logic [7:0]  exp_cpu_do   = '0;
    logic [7:0]  exp_vid_data = '0;
    bit [7:0]    ref_mem [0:65535];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) ref_mem[pre_a] <= pre_d;
        if (rst) begin
            g_valid      <= 1'b0;
            free_at      <= cyc + 1;
            starve       <= 0;
            exp_cpu_do   <= '0;
            exp_vid_data <= '0;
        end else begin
            if (cyc >= free_at && (bus.cpu_req || bus.vid_req)) begin
                g_valid <= 1'b1;
                g_cyc   <= cyc;
                free_at <= cyc + WS + 3;
                if (bus.cpu_req && (!bus.vid_req || starve == LIMIT)) begin
                    g_cpu   <= 1'b1;
                    g_write <= !bus.cpu_rw;
                    g_addr  <= bus.cpu_addr;
                    g_data  <= bus.cpu_di;
                    g_rdata <= ref_mem[bus.cpu_addr];
                    if (!bus.cpu_rw) ref_mem[bus.cpu_addr] <= bus.cpu_di;
                    starve  <= 0;
                end else begin
                    g_cpu   <= 1'b0;
                    g_write <= 1'b0;
                    g_addr  <= bus.vid_addr;
                    g_rdata <= ref_mem[bus.vid_addr];
                    if (bus.cpu_req && starve < LIMIT) starve <= starve + 1;
                end
            end
            if (g_valid && !g_write && (cyc + 1 == g_cyc + WS + 2)) begin
                if (g_cpu) exp_cpu_do   <= g_rdata;
                else       exp_vid_data <= g_rdata;
            end
        end
    end

    function automatic bit exp_active();
        return g_valid && (cyc > g_cyc) && (cyc <= g_cyc + 1 + WS);
    endfunction

    function automatic bit exp_done();
        return g_valid && (cyc == g_cyc + WS + 2);
    endfunction

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_ce",       bus.mem_ce,       0);
            check("rst_mem_we",       bus.mem_we,       0);
            check("rst_mem_addr",     bus.mem_addr,     0);
            check("rst_mem_dout",     bus.mem_dout,     0);
            check("rst_cpu_complete", bus.cpu_complete, 0);
            check("rst_vid_complete", bus.vid_complete, 0);
            check("rst_cpu_do",       bus.cpu_do,       0);
            check("rst_vid_data",     bus.vid_data,     0);
        end else begin
            check("mem_ce", bus.mem_ce, exp_active());
            check("mem_we", bus.mem_we, exp_active() && g_write);
            if (exp_active())            check("mem_addr", bus.mem_addr, g_addr);
            if (exp_active() && g_write) check("mem_dout", bus.mem_dout, g_data);
            check("cpu_complete", bus.cpu_complete, exp_done() && g_cpu);
            check("vid_complete", bus.vid_complete, exp_done() && !g_cpu);
            check("cpu_do",   bus.cpu_do,   exp_cpu_do);
            check("vid_data", bus.vid_data, exp_vid_data);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One CPU access from an idle start; lat counts cycles from raise to complete.
    task automatic do_cpu(input bit rw, input logic [15:0] a, input logic [7:0] d,
                          output int lat, output int n_we, output bit dout_ok);
        repeat (2) @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = a; bus.cpu_di = d;
        lat = -1; n_we = 0; dout_ok = 1'b1;
        for (int i = 0; i < 30 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                n_we++;
                if (bus.mem_dout !== d) dout_ok = 1'b0;
            end
            if (bus.cpu_complete) lat = i + 1;
        end
        bus.cpu_req = 1'b0;
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int  lat, n_we, n_ce, t_vid, t_cpu, n_vid, n_cc, n_act;
        bit  ok, addr_ok;
        int  cpu_wait, vid_wait;

        bus.cpu_req = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = '0; bus.cpu_di = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;

        for (int i = 0; i < 16; i++) preload(16'h0100 + 16'(i), 8'($urandom));
        preload(16'h1230, 8'hA5);

        // Reset state
        check("reset_mem_ce",   bus.mem_ce,   0);
        check("reset_cpu_do",   bus.cpu_do,   0);
        check("reset_vid_data", bus.vid_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single video read
        repeat (2) @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 16'h1230;
        t_vid = -1; n_ce = 0; n_we = 0; addr_ok = 1'b1;
        for (int i = 0; i < 20 && t_vid < 0; i++) begin
            @(negedge clk);
            if (bus.mem_ce) begin
                n_ce++;
                if (bus.mem_addr !== 16'h1230) addr_ok = 1'b0;
            end
            if (bus.mem_we) n_we++;
            if (bus.vid_complete) begin
                t_vid = i + 1;
                bus.vid_req = 1'b0;
            end
        end
        bus.vid_req = 1'b0;
        check("vid_read_latency", t_vid, 3);
        check("vid_read_ce_cycles", n_ce, 2);
        check("vid_read_addr", addr_ok, 1);
        check("vid_read_no_we", n_we, 0);
        check("vid_read_data", bus.vid_data, 8'hA5);

        // CPU write then read back
        do_cpu(1'b0, 16'h0040, 8'h5A, lat, n_we, ok);
        check("cpu_write_latency", lat, 3);
        check("cpu_write_we_cycles", n_we, 2);
        check("cpu_write_dout", ok, 1);
        do_cpu(1'b1, 16'h0040, 8'h00, lat, n_we, ok);
        check("cpu_read_latency", lat, 3);
        check("cpu_read_no_we", n_we, 0);
        check("cpu_read_data", bus.cpu_do, 8'h5A);
        check("vid_data_unchanged", bus.vid_data, 8'hA5);

        // Simultaneous requests: video at +3, CPU at +7
        repeat (2) @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0100;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h1230;
        t_vid = -1; t_cpu = -1;
        for (int i = 0; i < 30 && t_cpu < 0; i++) begin
            @(negedge clk);
            if (bus.vid_complete) begin t_vid = i + 1; bus.vid_req = 1'b0; end
            if (bus.cpu_complete) begin t_cpu = i + 1; bus.cpu_req = 1'b0; end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        check("simul_vid_latency", t_vid, 3);
        check("simul_cpu_latency", t_cpu, 7);
        check("simul_cpu_data", bus.cpu_do, 8'hA5);

        // Starvation guard: video held continuously, CPU waiting
        repeat (2) @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0101;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h0040;
        n_vid = 0; t_cpu = -1;
        for (int i = 0; i < 100 && t_cpu < 0; i++) begin
            @(negedge clk);
            if (bus.vid_complete) n_vid++;
            if (bus.cpu_complete) begin t_cpu = i + 1; bus.cpu_req = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        check("starve_vid_grants", n_vid, 4);
        check("starve_cpu_latency", t_cpu, 19);
        t_vid = -1;
        for (int i = 0; i < 10 && t_vid < 0; i++) begin
            @(negedge clk);
            if (bus.vid_complete) t_vid = i + 1;
        end
        check("starve_vid_resumes", t_vid, 4);
        // Counter must have restarted: another four video grants before the CPU
        bus.cpu_req = 1'b1;
        n_vid = 0; t_cpu = -1;
        for (int i = 0; i < 100 && t_cpu < 0; i++) begin
            @(negedge clk);
            if (bus.vid_complete) n_vid++;
            if (bus.cpu_complete) begin t_cpu = i + 1; bus.cpu_req = 1'b0; end
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        check("starve_cleared_vid_grants", n_vid, 4);

        // Reset during the first ACCESS cycle of a CPU write
        repeat (3) @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 16'h0077; bus.cpu_di = 8'hC3;
        @(posedge clk);
        #1;
        check("prerst_mem_we", bus.mem_we, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_mem_we", bus.mem_we, 0);
        check("async_rst_mem_ce", bus.mem_ce, 0);
        n_cc = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.cpu_complete) n_cc++;
        end
        rst = 1'b0;
        t_cpu = -1;
        for (int i = 0; i < 20 && t_cpu < 0; i++) begin
            @(negedge clk);
            if (bus.cpu_complete) begin t_cpu = i + 1; bus.cpu_req = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        check("rst_no_complete", n_cc, 0);
        check("rst_rewrite_latency", t_cpu, 3);
        do_cpu(1'b1, 16'h0077, 8'h00, lat, n_we, ok);
        check("rst_rewrite_readback", bus.cpu_do, 8'hC3);

        // Idle: 100 cycles with no requests
        n_act = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.mem_ce || bus.mem_we || bus.cpu_complete || bus.vid_complete) n_act++;
        end
        check("idle_activity", n_act, 0);

        // Random traffic against the model
        cpu_wait = 0; vid_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cpu_req) begin
                if (bus.cpu_complete) begin
                    check("cpu_wait_bound", cpu_wait <= BOUND, 1);
                    bus.cpu_req = 1'b0;
                end else begin
                    cpu_wait++;
                    if (cpu_wait > BOUND) begin
                        check("cpu_wait_timeout", cpu_wait, BOUND);
                        bus.cpu_req = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_rw   = 1'($urandom_range(0, 1));
                bus.cpu_addr = 16'h0100 + 16'($urandom_range(0, 15));
                bus.cpu_di   = 8'($urandom);
                cpu_wait     = 0;
            end
            if (bus.vid_req) begin
                if (bus.vid_complete) begin
                    check("vid_wait_bound", vid_wait <= BOUND, 1);
                    bus.vid_req = 1'b0;
                end else begin
                    vid_wait++;
                    if (vid_wait > BOUND) begin
                        check("vid_wait_timeout", vid_wait, BOUND);
                        bus.vid_req = 1'b0;
                    end
                end
            end else if ($urandom_range(0, 1) == 0) begin
                bus.vid_req  = 1'b1;
                bus.vid_addr = 16'h0100 + 16'($urandom_range(0, 15));
                vid_wait     = 0;
            end
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
